// File: rtl/xor_cipher_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xor_cipher_pkg
//  Brief    : Shared types and constants for the XOR cipher receive deframer.
//  Revision : 1.0  initial release
// ============================================================================
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam int                BYTE_W            = 8;
    localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hB4;

    localparam int FILL_W     = 4;
    localparam int BIT_CNT_W  = 3;
    localparam int BYTE_CNT_W = 8;
    localparam int MISS_CNT_W = 4;
    localparam int STAT_W     = 8;

endpackage
`default_nettype wire

// File: rtl/xor_rx_deframer_if.sv
`default_nettype none
// ============================================================================
//  Module   : xor_rx_deframer_if
//  Brief    : Serial bit input and byte/frame status outputs of the deframer.
//  Revision : 1.0  initial release
// ============================================================================
interface xor_rx_deframer_if;
    import xor_cipher_pkg::*;

    logic              bit_i;
    logic              bit_en;
    logic [BYTE_W-1:0] byte_o;
    logic              byte_vld;
    logic              frame_start;
    logic              locked;
    logic              sync_lost;
    logic [STAT_W-1:0] frame_cnt;
    logic [STAT_W-1:0] miss_tot;

    // Deframer side
    modport master (
        input  bit_i, bit_en,
        output byte_o, byte_vld, frame_start, locked, sync_lost, frame_cnt, miss_tot
    );

    // Bit source / byte consumer side
    modport slave (
        output bit_i, bit_en,
        input  byte_o, byte_vld, frame_start, locked, sync_lost, frame_cnt, miss_tot
    );

endinterface
`default_nettype wire

// File: rtl/xor_bit_sipo.sv
`default_nettype none
// ============================================================================
//  Module   : xor_bit_sipo
//  Brief    : MSB-first serial-in window with sync clear and saturating fill.
//  Revision : 1.0  initial release
// ============================================================================
module xor_bit_sipo
    import xor_cipher_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_en,
    input  wire logic              i_bit,
    input  wire logic              i_clr,
    output logic      [BYTE_W-1:0] o_win,
    output logic                   o_full,
    output logic                   o_byte_done
);

    // Only the seven most recent bits are stored; the live bit completes the
    // 8-bit window, so o_win is the post-shift value in the sampling cycle.
    logic [BYTE_W-2:0] r_sh_q,   w_sh_d;
    logic [FILL_W-1:0] r_fill_q, w_fill_d;

    always_comb begin
        w_sh_d   = r_sh_q;
        w_fill_d = r_fill_q;
        if (i_clr) begin
            w_sh_d   = '0;
            w_fill_d = '0;
        end else if (i_en) begin
            w_sh_d = {r_sh_q[BYTE_W-3:0], i_bit};
            if (r_fill_q != FILL_W'(BYTE_W)) begin
                w_fill_d = r_fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_q   <= '0;
            r_fill_q <= '0;
        end else begin
            r_sh_q   <= w_sh_d;
            r_fill_q <= w_fill_d;
        end
    end

    assign o_win       = {r_sh_q, i_bit};
    assign o_full      = i_en && (r_fill_q >= FILL_W'(BYTE_W - 1));
    assign o_byte_done = i_en && (r_fill_q == FILL_W'(BYTE_W - 1));

endmodule
`default_nettype wire

// File: rtl/xor_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : xor_rx_deframer
//  Brief    : Sync-word hunting byte deframer with flywheel lock tracking.
//             Define XOR_RX_STATS_EN to enable frame_cnt / miss_tot counters.
//  Revision : 1.0  initial release
// ============================================================================
module xor_rx_deframer
    import xor_cipher_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int                FRAME_LEN = 4,
    parameter int                MISS_MAX  = 3
)(
    input  wire logic        clk,
    input  wire logic        rst,
    xor_rx_deframer_if.master bus
);

    localparam logic [BYTE_CNT_W-1:0] C_LAST_BYTE = BYTE_CNT_W'(FRAME_LEN - 1);
    localparam logic [MISS_CNT_W:0]   C_MISS_MAX  = (MISS_CNT_W + 1)'(MISS_MAX);

    state_t                r_state_q,       w_state_d;
    logic [BYTE_CNT_W-1:0] r_byte_cnt_q,    w_byte_cnt_d;
    logic [MISS_CNT_W-1:0] r_miss_cnt_q,    w_miss_cnt_d;
    logic [BYTE_W-1:0]     r_byte_q,        w_byte_d;
    logic                  r_byte_vld_q,    w_byte_vld_d;
    logic                  r_frame_start_q, w_frame_start_d;
    logic                  r_locked_q,      w_locked_d;
    logic                  r_sync_lost_q,   w_sync_lost_d;

    logic [BYTE_W-1:0]     w_shift;
    logic                  w_full;
    logic                  w_byte_done;
    logic                  w_sipo_clr;
    logic [MISS_CNT_W:0]   w_miss_inc;

    xor_bit_sipo u_sipo (
        .clk         (clk),
        .rst         (rst),
        .i_en        (bus.bit_en),
        .i_bit       (bus.bit_i),
        .i_clr       (w_sipo_clr),
        .o_win       (w_shift),
        .o_full      (w_full),
        .o_byte_done (w_byte_done)
    );

    assign w_miss_inc = {1'b0, r_miss_cnt_q} + (MISS_CNT_W + 1)'(1);

    // The SIPO is cleared at every byte boundary once locked, so its fill
    // count doubles as the bit-within-byte counter.
    always_comb begin
        w_state_d       = r_state_q;
        w_byte_cnt_d    = r_byte_cnt_q;
        w_miss_cnt_d    = r_miss_cnt_q;
        w_byte_d        = r_byte_q;
        w_byte_vld_d    = 1'b0;
        w_frame_start_d = 1'b0;
        w_sync_lost_d   = 1'b0;
        w_sipo_clr      = 1'b0;
        case (r_state_q)
            HUNT: begin
                if (w_full && (w_shift == SYNC_WORD)) begin
                    w_state_d    = PAYLOAD;
                    w_byte_cnt_d = '0;
                    w_miss_cnt_d = '0;
                    w_sipo_clr   = 1'b1;
                end
            end
            PAYLOAD: begin
                if (w_byte_done) begin
                    w_sipo_clr      = 1'b1;
                    w_byte_d        = w_shift;
                    w_byte_vld_d    = 1'b1;
                    w_frame_start_d = (r_byte_cnt_q == '0);
                    if (r_byte_cnt_q == C_LAST_BYTE) begin
                        w_state_d    = CHECK;
                        w_byte_cnt_d = '0;
                    end else begin
                        w_byte_cnt_d = r_byte_cnt_q + BYTE_CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                if (w_byte_done) begin
                    w_sipo_clr = 1'b1;
                    if (w_shift == SYNC_WORD) begin
                        w_miss_cnt_d = '0;
                        w_state_d    = PAYLOAD;
                    end else if (w_miss_inc < C_MISS_MAX) begin
                        w_miss_cnt_d = w_miss_inc[MISS_CNT_W-1:0];
                        w_state_d    = PAYLOAD;
                    end else begin
                        w_miss_cnt_d  = '0;
                        w_state_d     = HUNT;
                        w_sync_lost_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = HUNT;
            end
        endcase
        w_locked_d = (w_state_d != HUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= HUNT;
            r_byte_cnt_q    <= '0;
            r_miss_cnt_q    <= '0;
            r_byte_q        <= '0;
            r_byte_vld_q    <= 1'b0;
            r_frame_start_q <= 1'b0;
            r_locked_q      <= 1'b0;
            r_sync_lost_q   <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_byte_cnt_q    <= w_byte_cnt_d;
            r_miss_cnt_q    <= w_miss_cnt_d;
            r_byte_q        <= w_byte_d;
            r_byte_vld_q    <= w_byte_vld_d;
            r_frame_start_q <= w_frame_start_d;
            r_locked_q      <= w_locked_d;
            r_sync_lost_q   <= w_sync_lost_d;
        end
    end

    assign bus.byte_o      = r_byte_q;
    assign bus.byte_vld    = r_byte_vld_q;
    assign bus.frame_start = r_frame_start_q;
    assign bus.locked      = r_locked_q;
    assign bus.sync_lost   = r_sync_lost_q;

`ifdef XOR_RX_STATS_EN
    logic              w_check_match;
    logic              w_check_miss;
    logic [STAT_W-1:0] r_frame_cnt_q, w_frame_cnt_d;
    logic [STAT_W-1:0] r_miss_tot_q,  w_miss_tot_d;

    assign w_check_match = (r_state_q == CHECK) && w_byte_done && (w_shift == SYNC_WORD);
    assign w_check_miss  = (r_state_q == CHECK) && w_byte_done && (w_shift != SYNC_WORD);

    always_comb begin
        w_frame_cnt_d = r_frame_cnt_q;
        w_miss_tot_d  = r_miss_tot_q;
        if (w_check_match && (r_frame_cnt_q != '1)) begin
            w_frame_cnt_d = r_frame_cnt_q + STAT_W'(1);
        end
        if (w_check_miss && (r_miss_tot_q != '1)) begin
            w_miss_tot_d = r_miss_tot_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt_q <= '0;
            r_miss_tot_q  <= '0;
        end else begin
            r_frame_cnt_q <= w_frame_cnt_d;
            r_miss_tot_q  <= w_miss_tot_d;
        end
    end

    assign bus.frame_cnt = r_frame_cnt_q;
    assign bus.miss_tot  = r_miss_tot_q;
`else
    assign bus.frame_cnt = '0;
    assign bus.miss_tot  = '0;
`endif

endmodule
`default_nettype wire
